instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction decode stage. Takes field-level instruction requests (op, regs, imm),
//  packs them into 32-bit ISA words and writes them sequentially into instruction memory.
//  Used by the program-loader / self-test path. Also expands pseudo-op LI (32-bit load) into LUI+LLI.
// PARAMETERS
//  ADDR_W   8   instruction-memory word-address width; DEPTH = 2**ADDR_W
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  in_valid       in   1       request valid
//  in_ready       out  1       request accepted when in_valid && in_ready
//  in_op          in   6       ISA opcode, or 6'h3F = LI pseudo-op
//  in_rd          in   5       dest reg (R-type, LUI/LLI, LOD, LI); data reg for STR
//  in_rs1         in   5       src1 (R-type, CMP); address reg for LOD/STR
//  in_rs2         in   5       src2 (R-type, CMP)
//  in_imm         in   32      imm16 in [15:0] (LUI/LLI), target in [25:0] (jumps), full value (LI)
//  addr_load      in   1       load write pointer
//  addr_load_val  in   ADDR_W  new write pointer
//  mem_we         out  1       instruction-memory write strobe
//  mem_addr       out  ADDR_W  write address
//  mem_wdata      out  32      encoded word
//  full           out  1       last address written; no further writes until addr_load
//  err_illegal    out  1       1-cycle pulse: unknown opcode consumed, nothing written
//  err_range      out  1       1-cycle pulse: imm out of field range (or LI with 1 slot left), nothing written
//  wr_count       out  ADDR_W+1  words written since reset/addr_load
// BEHAVIOUR
//  Reset: state IDLE; mem_we, err_*, full = 0; mem_addr, mem_wdata, wr_count = 0.
//  Opcodes: NOP 00 ADD 01 SUB 02 MUL 03 AND 04 OR 05 JMP 06 LUI 07 LLI 08 CMP 0A JEQ 0B LOD 0C
//   STR 0D XOR 0E XNOR 0F SHL 10 SHR 11 JNE 12. Anything else (incl. 09) except 3F -> illegal.
//  Encoding: R-type (ADD..OR,XOR..SHR) {op,rs1,rs2,rd,11'b0}; CMP {op,rs1,rs2,16'b0};
//   JMP/JEQ/JNE {op,imm[25:0]}; LUI/LLI {op,rd,5'b0,imm[15:0]}; LOD/STR {op,rd,rs1,16'b0}; NOP 32'h0.
//  Range: LUI/LLI need imm[31:16]==0; jumps need imm[31:26]==0; else err_range.
//  LI: writes LUI rd,imm[31:16] then LLI rd,imm[15:0] at consecutive addresses.
//  States: IDLE (mem_we=0) | WR (mem_we=1, single word) | LI1 (mem_we=1, LUI word; LLI pending).
//   accept non-LI -> WR; accept LI -> LI1; LI1 -> WR (LLI word); WR w/o accept -> IDLE; reject -> IDLE.
//  Latency: word on mem_* exactly 1 cycle after accept; throughput 1 word/cycle, LI occupies 2 cycles.
//  in_ready = !full && !addr_load && state!=LI1. Rejected requests are consumed (handshake completes).
//  mem_addr increments after each write; wr_count +1 per write. Write at DEPTH-1 sets full;
//   pointer wraps to 0 but no write occurs while full.
//  LI accepted when exactly one slot remains (addr==DEPTH-1) -> err_range, nothing written.
//  addr_load: mem_addr<=addr_load_val, full<=0, wr_count<=0; aborts pending LLI (state->IDLE,
//   LLI dropped); write already on mem_* that cycle still completes at old address.
//  Errors pulse the cycle after the offending accept, aligned with where mem_we would have been.
// CONFIGURATION
//  INSTR_ENC_CHECKSUM_EN defined: extra port checksum out 32 = running XOR of every mem_wdata
//   written; cleared by reset and addr_load. Undefined: port and logic absent.
// TESTING
//  ADD rd=3 rs1=1 rs2=2 at addr 0 -> next cycle mem_we=1 addr 0 data 32'h04221800, wr_count=1.
//  LI rd=5 imm=32'hDEADBEEF -> LUI 32'h1CA0DEAD @n, LLI 32'h20A0BEEF @n+1, in_ready low 1 cycle.
//  op=6'h09 then LUI imm=32'h0001_0000 -> err_illegal then err_range pulses, mem_we never high.
//  ADDR_W=2: write 4 JMP imm=0x10 -> full=1 after 4th, in_ready=0; addr_load 0 -> full=0, wr_count=0.
//  addr_load during LI1 -> LUI written at old addr, LLI dropped; ADDR_W=2, addr 3 + LI -> err_range.
//  Back-to-back 8 requests with in_valid held -> 8 consecutive writes, no bubbles.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field-level requests into 32-bit ISA words and writes them
// sequentially into instruction memory. LI expands to LUI + LLI at consecutive addresses.
// Optional feature: define INSTR_ENC_CHECKSUM_EN to add a running XOR checksum output.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic              err_illegal,
    output logic              err_range,
`ifdef INSTR_ENC_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [5:0] OpNop  = 6'h00;
    localparam logic [5:0] OpAdd  = 6'h01;
    localparam logic [5:0] OpSub  = 6'h02;
    localparam logic [5:0] OpMul  = 6'h03;
    localparam logic [5:0] OpAnd  = 6'h04;
    localparam logic [5:0] OpOr   = 6'h05;
    localparam logic [5:0] OpJmp  = 6'h06;
    localparam logic [5:0] OpLui  = 6'h07;
    localparam logic [5:0] OpLli  = 6'h08;
    localparam logic [5:0] OpCmp  = 6'h0A;
    localparam logic [5:0] OpJeq  = 6'h0B;
    localparam logic [5:0] OpLod  = 6'h0C;
    localparam logic [5:0] OpStr  = 6'h0D;
    localparam logic [5:0] OpXor  = 6'h0E;
    localparam logic [5:0] OpXnor = 6'h0F;
    localparam logic [5:0] OpShl  = 6'h10;
    localparam logic [5:0] OpShr  = 6'h11;
    localparam logic [5:0] OpJne  = 6'h12;
    localparam logic [5:0] OpLi   = 6'h3F;

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StLi1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wptr_q;      // next address to allocate
    logic [31:0]       li_lo_q;     // pending LLI word while in StLi1

    logic        accept;
    logic [31:0] enc_word;
    logic [31:0] enc_lo_word;
    logic        enc_illegal;
    logic        enc_range;
    logic        enc_is_li;

    assign in_ready = !full && !addr_load && (state_q != StLi1);
    assign accept   = in_valid && in_ready;

    // Field packing and legality/range classification of the incoming request
    always_comb begin
        enc_word    = 32'h0;
        enc_lo_word = {OpLli, in_rd, 5'b0, in_imm[15:0]};
        enc_illegal = 1'b0;
        enc_range   = 1'b0;
        enc_is_li   = 1'b0;
        case (in_op)
            OpNop: enc_word = 32'h0;
            OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpXnor, OpShl, OpShr:
                enc_word = {in_op, in_rs1, in_rs2, in_rd, 11'b0};
            OpCmp: enc_word = {in_op, in_rs1, in_rs2, 16'b0};
            OpJmp, OpJeq, OpJne: begin
                enc_word  = {in_op, in_imm[25:0]};
                enc_range = (in_imm[31:26] != 6'b0);
            end
            OpLui, OpLli: begin
                enc_word  = {in_op, in_rd, 5'b0, in_imm[15:0]};
                enc_range = (in_imm[31:16] != 16'b0);
            end
            OpLod, OpStr: enc_word = {in_op, in_rd, in_rs1, 16'b0};
            OpLi: begin
                enc_word  = {OpLui, in_rd, 5'b0, in_imm[31:16]};
                enc_is_li = 1'b1;
                // LI needs two slots; a single remaining slot cannot hold it
                enc_range = (wptr_q == LastAddr);
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    // Control FSM with registered memory-write and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            li_lo_q     <= 32'h0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
            wr_count    <= '0;
        end else begin
            mem_we      <= 1'b0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
            // When not writing, mem_addr tracks the next allocation address
            mem_addr    <= wptr_q;
            if (addr_load) begin
                // Any pending LLI is dropped; the word already on the bus completes as is
                state_q  <= StIdle;
                wptr_q   <= addr_load_val;
                mem_addr <= addr_load_val;
                full     <= 1'b0;
                wr_count <= '0;
            end else if (state_q == StLi1) begin
                state_q   <= StWr;
                mem_we    <= 1'b1;
                mem_addr  <= wptr_q;
                mem_wdata <= li_lo_q;
                wptr_q    <= wptr_q + ADDR_W'(1);
                wr_count  <= wr_count + (ADDR_W+1)'(1);
                if (wptr_q == LastAddr) full <= 1'b1;
            end else if (accept) begin
                if (enc_illegal) begin
                    state_q     <= StIdle;
                    err_illegal <= 1'b1;
                end else if (enc_range) begin
                    state_q   <= StIdle;
                    err_range <= 1'b1;
                end else begin
                    state_q   <= enc_is_li ? StLi1 : StWr;
                    li_lo_q   <= enc_lo_word;
                    mem_we    <= 1'b1;
                    mem_addr  <= wptr_q;
                    mem_wdata <= enc_word;
                    wptr_q    <= wptr_q + ADDR_W'(1);
                    wr_count  <= wr_count + (ADDR_W+1)'(1);
                    if (wptr_q == LastAddr) full <= 1'b1;
                end
            end else begin
                state_q <= StIdle;
            end
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    // Running XOR of every word presented on the write bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= 32'h0;
        end else if (addr_load) begin
            checksum <= 32'h0;
        end else if (mem_we) begin
            checksum <= checksum ^ mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_instr_encoder;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          addr_load;
    logic [AW-1:0] addr_load_val;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          full, err_illegal, err_range;
    logic [AW:0]   wr_count;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full),
        .err_illegal(err_illegal), .err_range(err_range),
`ifdef INSTR_ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: words still owed after the one on the bus, pointer, flags
    logic [31:0] owed[$];
    int          m_ptr, m_cnt;
    bit          m_full, m_ready;
    bit          e_we, e_ill, e_rng;
    int          e_addr;
    logic [31:0] e_data;
    bit          p_we;
    logic [31:0] p_data, m_sum;

    // kind: 0 = plain word, 1 = illegal, 2 = out of range, 3 = LI pseudo-op
    function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm, output int kind);
        logic [31:0] o, d, s1, s2;
        o = 32'(op) << 26; d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
        kind = 0;
        encode = 32'h0;
        case (int'(op))
            0: encode = 32'h0;
            1, 2, 3, 4, 5, 14, 15, 16, 17: encode = o + s1 * 2097152 + s2 * 65536 + d * 2048;
            10: encode = o + s1 * 2097152 + s2 * 65536;
            6, 11, 18: if (imm >= 32'd67108864) kind = 2; else encode = o + imm;
            7, 8: if (imm >= 32'd65536) kind = 2; else encode = o + d * 2097152 + imm;
            12, 13: encode = o + d * 2097152 + s1 * 65536;
            63: kind = 3;
            default: kind = 1;
        endcase
    endfunction

    function automatic void emit(input logic [31:0] w);
        e_we = 1; e_data = w; e_addr = m_ptr;
        if (m_ptr == DEPTH - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_cnt++;
    endfunction

    // One clock: drive a request at negedge, compare ready, then compare registered outputs
    task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic al, input logic [AW-1:0] alv);
        int kind, k2;
        logic [31:0] w;
        @(negedge clk);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        addr_load = al; addr_load_val = alv;
        #1;
        m_ready = !m_full && !al && (owed.size() == 0);
        check("in_ready", 32'(in_ready), 32'(m_ready));
        @(posedge clk);
        e_we = 0; e_ill = 0; e_rng = 0;
        if (al) m_sum = 32'h0;
        else if (p_we) m_sum = m_sum ^ p_data;
        if (al) begin
            m_ptr = int'(alv); m_full = 0; m_cnt = 0; owed.delete();
        end else if (owed.size() != 0) begin
            emit(owed.pop_front());
        end else if (v && m_ready) begin
            w = encode(op, rd, rs1, rs2, imm, kind);
            if (kind == 1) e_ill = 1;
            else if (kind == 2) e_rng = 1;
            else if (kind == 3) begin
                if (m_ptr == DEPTH - 1) e_rng = 1;
                else begin
                    emit(encode(6'h07, rd, 5'd0, 5'd0, imm >> 16, k2));
                    owed.push_back(encode(6'h08, rd, 5'd0, 5'd0, imm & 32'hFFFF, k2));
                end
            end else emit(w);
        end
        p_we = e_we; p_data = e_data;
        #1;
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), e_we ? 32'(e_addr) : 32'(m_ptr));
        if (e_we) check("mem_wdata", mem_wdata, e_data);
        check("err_illegal", 32'(err_illegal), 32'(e_ill));
        check("err_range", 32'(err_range), 32'(e_rng));
        check("full", 32'(full), 32'(m_full));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
`ifdef INSTR_ENC_CHECKSUM_EN
        check("checksum", checksum, m_sum);
`endif
    endtask

    task automatic idle();
        step(1'b0, 6'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, '0);
    endtask

    task automatic load(input logic [AW-1:0] a);
        step(1'b0, 6'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, a);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] rimm;
        int          r;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; addr_load = 1'b0; addr_load_val = '0;
        m_ptr = 0; m_cnt = 0; m_full = 0; p_we = 0; p_data = 0; m_sum = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst full", 32'(full), 32'h0);
        check("rst err_illegal", 32'(err_illegal), 32'h0);
        check("rst err_range", 32'(err_range), 32'h0);
        check("rst wr_count", 32'(wr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD r3, r1, r2 at address 0
        step(1'b1, 6'h01, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, '0);
        check("add word", mem_wdata, 32'h04221800);
        check("add addr", 32'(mem_addr), 32'h0);
        check("add count", 32'(wr_count), 32'h1);
        idle();

        // LI r5, 0xDEADBEEF with a follow-up request held to see the one-cycle stall
        step(1'b1, 6'h3F, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0, '0);
        check("li lui word", mem_wdata, 32'h1CA0DEAD);
        check("li lui addr", 32'(mem_addr), 32'h1);
        step(1'b1, 6'h01, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, '0);
        check("li lli word", mem_wdata, 32'h20A0BEEF);
        check("li lli addr", 32'(mem_addr), 32'h2);
        idle();

        // Illegal opcode then out-of-range LUI: pulses only, no writes
        step(1'b1, 6'h09, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, '0);
        check("op09 illegal", 32'(err_illegal), 32'h1);
        step(1'b1, 6'h07, 5'd1, 5'd0, 5'd0, 32'h0001_0000, 1'b0, '0);
        check("lui range", 32'(err_range), 32'h1);
        check("lui no write", 32'(mem_we), 32'h0);
        idle();

        // Back-to-back fill of the whole memory from address 0
        load('0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 6'h06, 5'd0, 5'd0, 5'd0, 32'h10, 1'b0, '0);
        idle();
        check("fill full", 32'(full), 32'h1);
        check("fill count", 32'(wr_count), 32'(DEPTH));
        idle();
        load('0);
        check("reload full", 32'(full), 32'h0);
        check("reload count", 32'(wr_count), 32'h0);

        // addr_load during the LLI slot drops the LLI
        load(AW'(DEPTH - 2));
        step(1'b1, 6'h3F, 5'd2, 5'd0, 5'd0, 32'h12345678, 1'b0, '0);
        check("abort lui addr", 32'(mem_addr), 32'(DEPTH - 2));
        load('0);
        check("abort no lli", 32'(mem_we), 32'h0);

        // LI with exactly one slot left
        load(AW'(DEPTH - 1));
        step(1'b1, 6'h3F, 5'd2, 5'd0, 5'd0, 32'h12345678, 1'b0, '0);
        check("li last slot", 32'(err_range), 32'h1);
        idle();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) rop = 6'($urandom_range(0, 18));
            else if (r < 9) rop = 6'h3F;
            else rop = 6'($urandom_range(0, 63));
            rimm = $urandom;
            r = int'($urandom_range(0, 3));
            if (r == 0) rimm = rimm & 32'hFFFF;
            else if (r == 1) rimm = rimm & 32'h03FF_FFFF;
            step($urandom_range(0, 9) < 8, rop, 5'($urandom), 5'($urandom), 5'($urandom),
                 rimm, $urandom_range(0, 19) == 0, AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
